// File: rtl/ide_sector_seq_if.sv
// Host command, sector-buffer and IDE access-engine signals of the single-sector sequencer.
// The slave modport is the sequencer's view; master is the host/engine side.
interface ide_sector_seq_if;
   logic        start;
   logic        cmd_write;
   logic [27:0] lba;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  err_code;
   logic [7:0]  buf_addr;
   logic        buf_we;
   logic [15:0] buf_dout;
   logic [15:0] buf_din;
   logic        ata_rd;
   logic        ata_wr;
   logic [4:0]  ata_addr;
   logic [15:0] ata_wdata;
   logic [15:0] ata_rdata;
   logic        ata_done;

   modport slave (
      input  start, cmd_write, lba, buf_din, ata_rdata, ata_done,
      output busy, done, error, err_code, buf_addr, buf_we, buf_dout,
             ata_rd, ata_wr, ata_addr, ata_wdata
   );

   modport master (
      output start, cmd_write, lba, buf_din, ata_rdata, ata_done,
      input  busy, done, error, err_code, buf_addr, buf_we, buf_dout,
             ata_rd, ata_wr, ata_addr, ata_wdata
   );
endinterface

// File: rtl/ide_sector_seq.sv
// Runs one READ SECTORS / WRITE SECTORS command (LBA28, one sector) through a
// register-level IDE access engine, moving 256 words to or from the sector buffer.
module ide_sector_seq #(
   parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
   input logic             clk,
   input logic             reset,
   ide_sector_seq_if.slave bus
);

   localparam logic [4:0] RegData   = 5'h10;
   localparam logic [4:0] RegCount  = 5'h12;
   localparam logic [4:0] RegLba0   = 5'h13;
   localparam logic [4:0] RegLba1   = 5'h14;
   localparam logic [4:0] RegLba2   = 5'h15;
   localparam logic [4:0] RegDev    = 5'h16;
   localparam logic [4:0] RegStatus = 5'h17;

   typedef enum logic [3:0] {
      StIdle, StRdy, StTfCnt, StTfL0, StTfL1, StTfL2, StTfDev, StTfCmd,
      StDrq, StXfer, StEnd, StFin, StFail
   } state_t;

   // PhIssue is also the mandatory idle cycle between two engine requests.
   typedef enum logic [1:0] {PhIssue, PhLoad, PhWait} phase_t;

   state_t      state_q, state_d;
   phase_t      ph_q, ph_d;
   logic [15:0] poll_q, poll_d, poll_inc;
   logic [7:0]  word_q, word_d;
   logic [27:0] lba_q, lba_d;
   logic        wr_q, wr_d;
   logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [7:0]  buf_addr_q, buf_addr_d;
   logic        buf_we_q, buf_we_d;
   logic [15:0] buf_dout_q, buf_dout_d;
   logic        ata_rd_q, ata_rd_d, ata_wr_q, ata_wr_d;
   logic [4:0]  ata_addr_q, ata_addr_d;
   logic [15:0] ata_wdata_q, ata_wdata_d;

   logic        acc_write, issue, poll_step, go_fin, go_fail;
   logic [4:0]  acc_addr;
   logic [15:0] acc_data;
   logic [1:0]  fail_code;
   logic        st_bsy, st_drq, st_err;

   assign st_bsy = bus.ata_rdata[7];
   assign st_drq = bus.ata_rdata[3];
   assign st_err = bus.ata_rdata[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         ph_q        <= PhIssue;
         poll_q      <= '0;
         word_q      <= '0;
         lba_q       <= '0;
         wr_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_code_q  <= '0;
         buf_addr_q  <= '0;
         buf_we_q    <= 1'b0;
         buf_dout_q  <= '0;
         ata_rd_q    <= 1'b0;
         ata_wr_q    <= 1'b0;
         ata_addr_q  <= '0;
         ata_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_d;
         poll_q      <= poll_d;
         word_q      <= word_d;
         lba_q       <= lba_d;
         wr_q        <= wr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_code_q  <= err_code_d;
         buf_addr_q  <= buf_addr_d;
         buf_we_q    <= buf_we_d;
         buf_dout_q  <= buf_dout_d;
         ata_rd_q    <= ata_rd_d;
         ata_wr_q    <= ata_wr_d;
         ata_addr_q  <= ata_addr_d;
         ata_wdata_q <= ata_wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ph_d        = ph_q;
      poll_d      = poll_q;
      word_d      = word_q;
      lba_d       = lba_q;
      wr_d        = wr_q;
      done_d      = 1'b0;
      error_d     = error_q;
      err_code_d  = err_code_q;
      buf_addr_d  = buf_addr_q;
      buf_we_d    = 1'b0;
      buf_dout_d  = buf_dout_q;
      ata_rd_d    = ata_rd_q;
      ata_wr_d    = ata_wr_q;
      ata_addr_d  = ata_addr_q;
      ata_wdata_d = ata_wdata_q;
      poll_inc    = poll_q + 16'd1;
      issue       = 1'b0;
      poll_step   = 1'b0;
      go_fin      = 1'b0;
      go_fail     = 1'b0;
      fail_code   = 2'd0;

      // Engine access belonging to the current state; status polls are the default.
      acc_write = 1'b1;
      acc_addr  = RegStatus;
      acc_data  = 16'h0000;
      unique case (state_q)
         StTfCnt: begin acc_addr = RegCount; acc_data = 16'h0001; end
         StTfL0:  begin acc_addr = RegLba0;  acc_data = {8'h00, lba_q[7:0]}; end
         StTfL1:  begin acc_addr = RegLba1;  acc_data = {8'h00, lba_q[15:8]}; end
         StTfL2:  begin acc_addr = RegLba2;  acc_data = {8'h00, lba_q[23:16]}; end
         StTfDev: begin acc_addr = RegDev;   acc_data = {8'h00, 4'b1110, lba_q[27:24]}; end
         StTfCmd: acc_data = {8'h00, wr_q ? 8'h30 : 8'h20};
         StXfer:  begin acc_write = wr_q; acc_addr = RegData; acc_data = bus.buf_din; end
         default: acc_write = 1'b0;
      endcase

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d    = StRdy;
               ph_d       = PhIssue;
               poll_d     = '0;
               lba_d      = bus.lba;
               wr_d       = bus.cmd_write;
               error_d    = 1'b0;
               err_code_d = 2'd0;
            end
         end
         StFin, StFail: state_d = StIdle;
         default: begin
            unique case (ph_q)
               // Write transfers spend PhIssue waiting for buf_din to follow buf_addr.
               PhIssue: begin
                  if (state_q == StXfer && wr_q) ph_d = PhLoad;
                  else                           issue = 1'b1;
               end
               PhLoad: issue = 1'b1;
               PhWait: begin
                  if (bus.ata_done) begin
                     ata_rd_d = 1'b0;
                     ata_wr_d = 1'b0;
                     ph_d     = PhIssue;
                     unique case (state_q)
                        StRdy: begin
                           if (!st_bsy) state_d = StTfCnt;
                           else         poll_step = 1'b1;
                        end
                        StTfCnt: state_d = StTfL0;
                        StTfL0:  state_d = StTfL1;
                        StTfL1:  state_d = StTfL2;
                        StTfL2:  state_d = StTfDev;
                        StTfDev: state_d = StTfCmd;
                        StTfCmd: begin state_d = StDrq; poll_d = '0; end
                        StDrq: begin
                           if (!st_bsy && st_drq) begin
                              state_d    = StXfer;
                              word_d     = '0;
                              buf_addr_d = '0;
                           end else if (!st_bsy && st_err) begin
                              go_fail   = 1'b1;
                              fail_code = 2'd1;
                           end else begin
                              poll_step = 1'b1;
                           end
                        end
                        StXfer: begin
                           if (!wr_q) begin
                              buf_dout_d = bus.ata_rdata;
                              buf_we_d   = 1'b1;
                              buf_addr_d = word_q;
                           end
                           if (word_q == 8'hFF) begin
                              if (wr_q) begin
                                 state_d = StEnd;
                                 poll_d  = '0;
                              end else begin
                                 go_fin = 1'b1;
                              end
                           end else begin
                              word_d = word_q + 8'd1;
                              if (wr_q) buf_addr_d = word_q + 8'd1;
                           end
                        end
                        StEnd: begin
                           if (st_bsy) begin
                              poll_step = 1'b1;
                           end else if (st_err) begin
                              go_fail   = 1'b1;
                              fail_code = 2'd1;
                           end else begin
                              go_fin = 1'b1;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
               default: ph_d = PhIssue;
            endcase
         end
      endcase

      if (issue) begin
         ata_rd_d    = !acc_write;
         ata_wr_d    = acc_write;
         ata_addr_d  = acc_addr;
         ata_wdata_d = acc_data;
         ph_d        = PhWait;
      end

      if (poll_step) begin
         if (poll_inc == POLL_LIMIT) begin
            go_fail   = 1'b1;
            fail_code = 2'd2;
         end else begin
            poll_d = poll_inc;
         end
      end

      if (go_fail) begin
         state_d    = StFail;
         done_d     = 1'b1;
         error_d    = 1'b1;
         err_code_d = fail_code;
      end else if (go_fin) begin
         state_d = StFin;
         done_d  = 1'b1;
      end

      busy_d = (state_d != StIdle);
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.error     = error_q;
   assign bus.err_code  = err_code_q;
   assign bus.buf_addr  = buf_addr_q;
   assign bus.buf_we    = buf_we_q;
   assign bus.buf_dout  = buf_dout_q;
   assign bus.ata_rd    = ata_rd_q;
   assign bus.ata_wr    = ata_wr_q;
   assign bus.ata_addr  = ata_addr_q;
   assign bus.ata_wdata = ata_wdata_q;

endmodule

// File: doc/ide_sector_seq.md
IDE_SECTOR_SEQ -- requirements
Module: ide_sector_seq

Interface
REQ-001 Parameter POLL_LIMIT, default 16'hFFFF, max status polls per wait state before timeout.
REQ-002 Ports, clock and reset first:
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle request to run a single-sector command.
- cmd_write  input  1  sampled with start; 0 = READ SECTORS (8'h20), 1 = WRITE SECTORS (8'h30).
- lba  input  28  sampled with start; sector address.
- busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
- done  output  1  one-cycle completion pulse.
- error  output  1  set with done on failure; held until the next accepted start.
- err_code  output  2  1 = device ERR bit, 2 = timeout; 0 otherwise.
- buf_addr  output  8  sector-buffer word index.
- buf_we  output  1  write strobe; buf_dout is stored at buf_addr.
- buf_dout  output  16  word read from the drive.
- buf_din  input  16  buffer word, valid one cycle after buf_addr changes.
- ata_rd  output  1  register-read request to the IDE access engine.
- ata_wr  output  1  register-write request to the IDE access engine.
- ata_addr  output  5  {cs[1:0], da[2:0]}.
- ata_wdata  output  16  write data to the engine.
- ata_rdata  input  16  engine read result, valid when ata_done is high.
- ata_done  input  1  engine one-cycle completion.

Function
REQ-003 All outputs are registered.
REQ-004 Register map: data 5'h10, sector count 5'h12, LBA0 5'h13, LBA1 5'h14, LBA2 5'h15, device 5'h16, status/command 5'h17.
REQ-005 Engine handshake:
- Raise exactly one of ata_rd/ata_wr with ata_addr and ata_wdata stable.
- Hold all of them until ata_done is sampled high.
- Deassert the request on that same edge.
- Keep the request low for at least one full cycle before the next request.
REQ-006 Requests and ata_done are never high in IDLE. A spurious ata_done is ignored.
REQ-007 start is accepted only in IDLE. start while busy is ignored and does not change the latched lba or cmd_write.
REQ-008 States:
- IDLE: accepted start -> RDY.
- RDY: read status until BSY (bit 7) = 0 -> TF_CNT.
- TF_CNT: write 8'h01.
- TF_L0: write lba[7:0].
- TF_L1: write lba[15:8].
- TF_L2: write lba[23:16].
- TF_DEV: write {4'b1110, lba[27:24]}.
- TF_CMD: write the command opcode.
- DRQ: read status until BSY = 0 and DRQ (bit 3) = 1 -> XFER, or BSY = 0 and ERR (bit 0) = 1 -> FAIL.
- XFER: 256 data-register accesses.
- READ path: XFER -> FIN.
- WRITE path: XFER -> END. END reads status until BSY = 0, then goes to FIN, or to FAIL if ERR = 1.
- FIN: done = 1, error = 0 -> IDLE.
- FAIL: done = 1, error = 1 -> IDLE.
REQ-009 Write-register data is zero-extended to 16 bits in ata_wdata[15:8].
REQ-010 Poll counter:
- Cleared on entry to RDY, DRQ and END.
- Increments once per completed status read.
- When it reaches POLL_LIMIT without the exit condition: FAIL with err_code = 2.
- Device ERR seen during the DRQ or END checks: err_code = 1.
REQ-011 READ transfer, word k = 0..255:
- Issue ata_rd at 5'h10.
- On ata_done, register ata_rdata into buf_dout with buf_addr = k.
- Pulse buf_we for one cycle.
REQ-012 WRITE transfer, word k = 0..255:
- Drive buf_addr = k.
- Wait one cycle, then load buf_din into ata_wdata and issue ata_wr at 5'h10.
REQ-013 The word index is 8 bits. Exit XFER when the access for k = 255 completes; the index wrap to 0 is not used as a condition.
REQ-014 busy is low in IDLE and high in every other state, including FIN/FAIL up to their exit edge.

Reset
REQ-015 While reset is high, regardless of clk:
- State = IDLE.
- busy, done, error, buf_we, ata_rd, ata_wr = 0.
- err_code, buf_addr, buf_dout, ata_addr, ata_wdata = 0.
- Poll counter, word index, latched lba and latched cmd_write = 0.
REQ-016 Reset during any state aborts the command, with no done pulse. The engine shares the same reset, so no stale handshake survives.

Verification
REQ-017 Directed scenarios:
- Read lba = 28'h0123456: status returns 8'h80 twice then 8'h50; DRQ-check status 8'h58; data words 16'h0000..16'h00FF. Required: writes 12<-01, 13<-56, 14<-34, 15<-12, 16<-E0, 17<-20; 256 buf_we pulses with buf_dout = buf_addr; done = 1, error = 0.
- Write lba = 28'hFFFFFFF: buf_din = ~buf_addr. Required: 16<-EF, 17<-30; 256 ata_wr to 5'h10 with data ~k; END poll of 8'h50; done, error = 0.
- DRQ-check status 8'h51. Required: no data access; done = 1, error = 1, err_code = 1.
- POLL_LIMIT = 4 with status stuck at 8'h80. Required: exactly 4 status reads, then done = 1, error = 1, err_code = 2.
- start pulsed during XFER with a different lba. Required: ignored; the transfer completes unchanged; a subsequent start is accepted.
- reset asserted mid-XFER (k = 100). Required: outputs reach reset values immediately; no done pulse; the next start runs a full command.
